// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, lane word type, FSM states and bit-reversal helper
package fft_pkg;

  localparam int NBITS_OUT = 15;
  localparam int N         = 128;
  localparam int LOG2N     = 7;
  localparam int BEATS     = N / 4;
  localparam int CW        = LOG2N - 2;

  typedef struct packed {
    logic [NBITS_OUT-1:0] re;
    logic [NBITS_OUT-1:0] im;
  } lane_word_t;

  typedef enum logic { W_IDLE, W_FILL } wr_state_t;
  typedef enum logic { R_IDLE, R_READ } rd_state_t;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - one reorder bank: 4 bit-reversed write ports, 4 natural read ports, full flag
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_beat,
  input  lane_word_t [3:0] wr_data,
  input  logic             set_full,
  input  logic             clr_full,
  input  logic [CW-1:0]    rd_beat,
  output lane_word_t [3:0] rd_data,
  output logic             full
);

  lane_word_t mem [N];
  logic [3:0][LOG2N-1:0] wr_addr;

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      wr_addr[l] = LOG2N'(bitrev(32'({wr_beat, 2'(l)}), LOG2N));
      rd_data[l] = mem[{rd_beat, 2'(l)}];
    end
  end

  // Contents are deliberately left unreset; the full flag alone gates reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) mem[wr_addr[l]] <= wr_data[l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder of bit-reversed 4-lane FFT output into natural bin order
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [2*NBITS_OUT-1:0] in0_up,
  input  logic [2*NBITS_OUT-1:0] in0_down,
  input  logic [2*NBITS_OUT-1:0] in1_up,
  input  logic [2*NBITS_OUT-1:0] in1_down,
  output logic [2*NBITS_OUT-1:0] out0,
  output logic [2*NBITS_OUT-1:0] out1,
  output logic [2*NBITS_OUT-1:0] out2,
  output logic [2*NBITS_OUT-1:0] out3,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   err_sof
);

  wr_state_t        w_state;
  logic [CW-1:0]    wr_cnt;
  logic             wr_ptr;
  rd_state_t        r_state;
  logic [CW-1:0]    rd_cnt;
  logic             rd_ptr;

  lane_word_t [3:0] in_lanes;
  lane_word_t [3:0] rd_data [2];
  lane_word_t [3:0] rd_sel;
  logic [1:0]       full;

  logic             wr_en, wr_last, abort;
  logic [CW-1:0]    wr_beat;
  logic             rd_go, rd_release;
  logic [CW-1:0]    rd_beat;

  assign in_lanes = {in1_down, in1_up, in0_down, in0_up};
  assign rd_sel   = rd_data[rd_ptr];

  always_comb begin
    wr_en   = 1'b0;
    wr_last = 1'b0;
    abort   = 1'b0;
    wr_beat = wr_cnt;
    if (in_valid) begin
      if (w_state == W_IDLE) begin
        wr_en   = in_sof;
        wr_beat = '0;
      end else if (in_sof && wr_cnt != '0) begin
        // Early sof: restart in the same bank, partial frame is simply overwritten.
        wr_en   = 1'b1;
        wr_beat = '0;
        abort   = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_last = (wr_cnt == CW'(BEATS-1));
      end
    end
  end

  // Beat 0 is emitted on the same edge that first sees the bank full, so no bubble between banks.
  always_comb begin
    rd_go      = (r_state == R_READ) || full[rd_ptr];
    rd_beat    = (r_state == R_READ) ? rd_cnt : '0;
    rd_release = rd_go && (rd_beat == CW'(BEATS-1));
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en && (wr_ptr == 1'(b))),
      .wr_beat  (wr_beat),
      .wr_data  (in_lanes),
      .set_full (wr_en && wr_last && (wr_ptr == 1'(b))),
      .clr_full (rd_release && (rd_ptr == 1'(b))),
      .rd_beat  (rd_beat),
      .rd_data  (rd_data[b]),
      .full     (full[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      wr_cnt  <= '0;
      wr_ptr  <= 1'b0;
      err_sof <= 1'b0;
    end else begin
      err_sof <= abort;
      if (wr_en) begin
        if (wr_last) begin
          w_state <= W_IDLE;
          wr_cnt  <= '0;
          wr_ptr  <= ~wr_ptr;
        end else begin
          w_state <= W_FILL;
          wr_cnt  <= wr_beat + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= R_IDLE;
      rd_cnt    <= '0;
      rd_ptr    <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (rd_go) begin
      out0      <= rd_sel[0];
      out1      <= rd_sel[1];
      out2      <= rd_sel[2];
      out3      <= rd_sel[3];
      out_valid <= 1'b1;
      out_sof   <= (rd_beat == '0);
      out_eof   <= rd_release;
      if (rd_release) begin
        rd_ptr  <= ~rd_ptr;
        rd_cnt  <= '0;
        r_state <= full[~rd_ptr] ? R_READ : R_IDLE;
      end else begin
        r_state <= R_READ;
        rd_cnt  <= rd_beat + CW'(1);
      end
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - randomized self-checking bench for fft_out_reorder
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int W = 2*NBITS_OUT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0;
  logic [W-1:0] in0_up = '0, in0_down = '0, in1_up = '0, in1_down = '0;
  logic [W-1:0] out0, out1, out2, out3;
  logic out_valid, out_sof, out_eof, err_sof;

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in0_up(in0_up), .in0_down(in0_down), .in1_up(in1_up), .in1_down(in1_down),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .err_sof(err_sof)
  );

  typedef struct packed {
    logic [3:0][W-1:0] d;
    logic sof;
    logic eof;
  } beat_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    obs_cyc[$];
  beat_t mon_b;
  int cyc = 0, err_cnt = 0, stray = 0;
  int vectors = 0, miscompares = 0;
  int last_cyc;
  logic [W-1:0] cur [N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      mon_b.d   = {out3, out2, out1, out0};
      mon_b.sof = out_sof;
      mon_b.eof = out_eof;
      obs_q.push_back(mon_b);
      obs_cyc.push_back(cyc);
    end else if (out_sof || out_eof) begin
      stray++;
    end
    if (err_sof) err_cnt++;
  end

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (x[i]) r |= 1 << (LOG2N-1-i);
    return r;
  endfunction

  task automatic clear_sb();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete(); err_cnt = 0;
  endtask

  task automatic fill_random();
    for (int b = 0; b < N; b++) cur[b] = W'($urandom);
  endtask

  task automatic fill_ramp();
    for (int b = 0; b < N; b++) cur[b] = {NBITS_OUT'(b), NBITS_OUT'(-b)};
  endtask

  task automatic fill_sat();
    int pick;
    for (int b = 0; b < N; b++) begin
      pick = $urandom_range(3);
      cur[b] = {(pick[0] ? 15'h3FFF : 15'h4000), (pick[1] ? 15'h3FFF : 15'h4000)};
    end
  endtask

  // Natural order: read beat r carries bins 4r..4r+3.
  task automatic add_expect();
    beat_t b;
    for (int r = 0; r < BEATS; r++) begin
      for (int k = 0; k < 4; k++) b.d[k] = cur[4*r+k];
      b.sof = (r == 0);
      b.eof = (r == BEATS-1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input int c, input logic sof);
    in_valid = 1'b1;
    in_sof   = sof;
    in0_up   = cur[brev(4*c+0)];
    in0_down = cur[brev(4*c+1)];
    in1_up   = cur[brev(4*c+2)];
    in1_down = cur[brev(4*c+3)];
    @(posedge clk); #1;
  endtask

  task automatic idle_beat();
    in_valid = 1'b0;
    in_sof   = 1'($urandom_range(1));
    in0_up   = W'($urandom);
    in1_down = W'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int gap_pct, input int nbeats);
    for (int c = 0; c < nbeats; c++) begin
      if (c != 0 && $urandom_range(99) < gap_pct) idle_beat();
      drive_beat(c, 1'(c == 0));
    end
    last_cyc = cyc;
  endtask

  task automatic quiet(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, out_sof, out_eof, err_sof, out0, out1, out2, out3} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", {out_valid, out_sof, out_eof, err_sof, out0, out1, out2, out3});
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    clear_sb(); fill_ramp(); add_expect();
    drive_frame(0, BEATS);
    quiet(45);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL ramp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL ramp_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_cyc.size() == BEATS) begin
      vectors++;
      if (obs_cyc[0] !== last_cyc + 1) begin
        miscompares++; $display("FAIL ramp_latency: got cycle %0d want %0d", obs_cyc[0], last_cyc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    fill_random(); add_expect(); drive_frame(0, BEATS);
    fill_random(); add_expect(); drive_frame(0, BEATS);
    quiet(80);
    vectors++;
    if (obs_q.size() !== 2*BEATS) begin
      miscompares++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 2*BEATS);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL b2b_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_cyc.size() == 2*BEATS) begin
      vectors++;
      if (obs_cyc[2*BEATS-1] - obs_cyc[0] !== 2*BEATS-1) begin
        miscompares++; $display("FAIL b2b_contiguous: got span %0d want %0d", obs_cyc[2*BEATS-1] - obs_cyc[0], 2*BEATS-1);
      end
    end
  endtask

  task automatic test_gaps();
    clear_sb(); fill_ramp(); add_expect();
    drive_frame(50, BEATS);
    quiet(45);
    vectors++;
    if (obs_q.size() !== BEATS) begin
      miscompares++; $display("FAIL gaps_count: got %0d want %0d", obs_q.size(), BEATS);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL gaps_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_cyc.size() == BEATS) begin
      vectors++;
      if (obs_cyc[BEATS-1] - obs_cyc[0] !== BEATS-1 || obs_cyc[0] !== last_cyc + 1) begin
        miscompares++; $display("FAIL gaps_timing: got start %0d span %0d want start %0d span %0d",
                                obs_cyc[0], obs_cyc[BEATS-1] - obs_cyc[0], last_cyc + 1, BEATS-1);
      end
    end
  endtask

  task automatic test_abort();
    clear_sb();
    fill_random(); drive_frame(0, 10);
    fill_random(); add_expect(); drive_frame(0, BEATS);
    quiet(45);
    vectors++;
    if (err_cnt !== 1) begin
      miscompares++; $display("FAIL abort_err_sof: got %0d pulses want 1", err_cnt);
    end
    vectors++;
    if (obs_q.size() !== BEATS) begin
      miscompares++; $display("FAIL abort_count: got %0d want %0d", obs_q.size(), BEATS);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL abort_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_sb(); fill_sat(); add_expect();
    drive_frame(25, BEATS);
    quiet(45);
    vectors++;
    if (obs_q.size() !== BEATS) begin
      miscompares++; $display("FAIL sat_count: got %0d want %0d", obs_q.size(), BEATS);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL sat_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset at input beat 20; trailing beats without sof must be ignored.
    clear_sb(); fill_random();
    drive_frame(0, 20);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_sof, out_eof, err_sof, out0, out1, out2, out3} !== '0) begin
      miscompares++; $display("FAIL rst_in_write: got %h want 0", {out_valid, out_sof, out_eof, err_sof, out0, out1, out2, out3});
    end
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 20; c < BEATS; c++) drive_beat(c, 1'b0);
    quiet(45);
    vectors++;
    if (obs_q.size() !== 0) begin
      miscompares++; $display("FAIL rst_write_output: got %0d beats want 0", obs_q.size());
    end
    // Reset while read beat 5 is on the outputs.
    clear_sb(); fill_random(); add_expect();
    drive_frame(0, BEATS);
    quiet(6);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_sof, out_eof, out0, out1, out2, out3} !== '0) begin
      miscompares++; $display("FAIL rst_in_read: got %h want 0", {out_valid, out_sof, out_eof, out0, out1, out2, out3});
    end
    @(posedge clk); #3 rst = 1'b1;
    quiet(45);
    vectors++;
    if (obs_q.size() !== 5) begin
      miscompares++; $display("FAIL rst_read_count: got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 5; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL rst_read_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    // A fresh frame after reset comes out intact.
    clear_sb(); fill_random(); add_expect();
    drive_frame(0, BEATS);
    quiet(45);
    vectors++;
    if (obs_q.size() !== BEATS) begin
      miscompares++; $display("FAIL rst_recover_count: got %0d want %0d", obs_q.size(), BEATS);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL rst_recover_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_saturation();
    test_reset_mid();
    vectors++;
    if (stray !== 0) begin
      miscompares++; $display("FAIL stray_sof_eof: got %0d cycles want 0", stray);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
